// File: rtl/vga_timing_monitor.sv
// VGA receive-side timing monitor: recovers coordinates, data-enable and lock from hs/vs,
// flags line/frame length errors and captures one probe pixel. `VGA_MON_CRC_EN adds a frame CRC.
module vga_timing_monitor #(
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_ACT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hs,
    input  logic        vs,
    input  logic [2:0]  r,
    input  logic [2:0]  g,
    input  logic [2:0]  b,
    input  logic [10:0] probe_x,
    input  logic [10:0] probe_y,
    input  logic        err_clr,
    output logic        locked,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [8:0]  probe_rgb,
    output logic        probe_vld,
    output logic        err_line,
    output logic        err_frame,
    output logic [7:0]  frame_cnt
`ifdef VGA_MON_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_vld
`endif
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_VIS);
    localparam logic [10:0] V_START = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_END   = 11'(V_SYNC + V_BP + V_VIS);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {StSearch, StAcquire, StLocked} stateT;

    stateT       stateQ, stateD;
    logic        skipQ, skipD;
    logic        hsQ, vsQ;
    logic [8:0]  rgbQ;
    logic [10:0] hcnt, vcnt;
    logic        hsEdge, vsEdge, lineBad, frameBad;
    logic        lineErr, frameErr, frameOk;
    logic        hIn, vIn, probeHit;

    // Edge: incoming sample active while the previously registered sample was not.
    assign hsEdge   = (hs == SYNC_ACT) && (hsQ != SYNC_ACT);
    assign vsEdge   = (vs == SYNC_ACT) && (vsQ != SYNC_ACT);
    assign lineBad  = hsEdge && (hcnt != H_LAST);
    assign frameBad = vsEdge && (vcnt != V_LAST);

    assign locked   = (stateQ == StLocked);
    assign hIn      = (hcnt >= H_START) && (hcnt < H_END);
    assign vIn      = (vcnt >= V_START) && (vcnt < V_END);
    assign de       = locked && hIn && vIn;
    assign x        = de ? (hcnt - H_START) : 11'd0;
    assign y        = de ? (vcnt - V_START) : 11'd0;
    assign probeHit = de && (x == probe_x) && (y == probe_y);

    always_comb begin
        stateD   = stateQ;
        skipD    = skipQ;
        lineErr  = 1'b0;
        frameErr = 1'b0;
        frameOk  = 1'b0;
        if (pix_en) begin
            unique case (stateQ)
                StSearch: begin
                    if (vsEdge) begin
                        stateD = StAcquire;
                        skipD  = 1'b1;
                    end
                end
                StAcquire: begin
                    // The first line after entry may be partial, so its length is ignored.
                    if (hsEdge && skipQ) skipD = 1'b0;
                    if (lineBad && !skipQ) begin
                        lineErr = 1'b1;
                        stateD  = StSearch;
                    end else if (vsEdge) begin
                        stateD = StLocked;
                    end
                end
                StLocked: begin
                    lineErr  = lineBad;
                    frameErr = frameBad;
                    frameOk  = vsEdge && !frameBad;
                    if (lineBad || frameBad) stateD = StSearch;
                end
                default: stateD = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ    <= StSearch;
            skipQ     <= 1'b0;
            hsQ       <= ~SYNC_ACT;
            vsQ       <= ~SYNC_ACT;
            rgbQ      <= 9'd0;
            hcnt      <= 11'd0;
            vcnt      <= 11'd0;
            probe_rgb <= 9'd0;
            probe_vld <= 1'b0;
            err_line  <= 1'b0;
            err_frame <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            stateQ    <= stateD;
            skipQ     <= skipD;
            probe_vld <= 1'b0;
            // A new error in the same cycle as err_clr keeps the flag set.
            err_line  <= (err_line & ~err_clr) | lineErr;
            err_frame <= (err_frame & ~err_clr) | frameErr;
            if (pix_en) begin
                hsQ  <= hs;
                vsQ  <= vs;
                rgbQ <= {r, g, b};
                if (hsEdge)                hcnt <= 11'd0;
                else if (hcnt != CNT_MAX)  hcnt <= hcnt + 11'd1;
                if (vsEdge)                         vcnt <= 11'd0;
                else if (hsEdge && vcnt != CNT_MAX) vcnt <= vcnt + 11'd1;
                if (frameOk) frame_cnt <= frame_cnt + 8'd1;
                if (probeHit) begin
                    probe_rgb <= rgbQ;
                    probe_vld <= 1'b1;
                end
            end
        end
    end

`ifdef VGA_MON_CRC_EN
    logic [15:0] crcQ, crcNext;
    logic        fb;

    // CRC-16-CCITT, 9 bits per sample, MSB first.
    always_comb begin
        crcNext = crcQ;
        fb      = 1'b0;
        for (int i = 8; i >= 0; i--) begin
            fb      = crcNext[15] ^ rgbQ[i];
            crcNext = {crcNext[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crcQ      <= 16'hFFFF;
            frame_crc <= 16'd0;
            crc_vld   <= 1'b0;
        end else begin
            crc_vld <= 1'b0;
            if (pix_en) begin
                if (vsEdge) begin
                    crcQ <= 16'hFFFF;
                    if (locked) begin
                        frame_crc <= crcQ;
                        crc_vld   <= 1'b1;
                    end
                end else if (de) begin
                    crcQ <= crcNext;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a scaled-down raster (8x6 total, 4x3 visible)
// so that lock, error and 256-frame wrap scenarios fit a short run.
module tb_vga_timing_monitor;

    localparam int HV = 4, HF = 1, HS = 2, HB = 1, HT = 8, HO = 3;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1, VT = 6, VO = 2;

    logic        clk = 1'b0, rst = 1'b0, pix_en = 1'b0, hs = 1'b1, vs = 1'b1, err_clr = 1'b0;
    logic [2:0]  r = 3'd0, g = 3'd0, b = 3'd0;
    logic [10:0] probe_x = 11'd700, probe_y = 11'd0;
    logic        locked, de, probe_vld, err_line, err_frame;
    logic [10:0] x, y;
    logic [8:0]  probe_rgb;
    logic [7:0]  frame_cnt;
`ifdef VGA_MON_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_vld;
    int          crcCnt = 0;
`endif

    always #5 clk = ~clk;

    vga_timing_monitor #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACT(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hs(hs), .vs(vs),
        .r(r), .g(g), .b(b), .probe_x(probe_x), .probe_y(probe_y), .err_clr(err_clr),
        .locked(locked), .de(de), .x(x), .y(y), .probe_rgb(probe_rgb), .probe_vld(probe_vld),
        .err_line(err_line), .err_frame(err_frame), .frame_cnt(frame_cnt)
`ifdef VGA_MON_CRC_EN
        , .frame_crc(frame_crc), .crc_vld(crc_vld)
`endif
    );

    int   nChecks = 0, nPass = 0;
    int   deCnt, xyBad, xMax, yMax, unlockPos, probeCnt = 0;
    logic prevLocked = 1'b0;
    bit   zeroRgb = 1'b0, probeOn = 1'b0;

    always @(negedge clk) if (probe_vld) probeCnt++;
`ifdef VGA_MON_CRC_EN
    always @(negedge clk) if (crc_vld) crcCnt++;

    function automatic int crc_model(input int nZeroSamples);
        logic [15:0] c = 16'hFFFF;
        logic        f;
        for (int i = 0; i < nZeroSamples * 9; i++) begin
            f = c[15];
            c = {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
        end
        return int'(c);
    endfunction
`endif

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic put_sample(input logic hv, input logic vv, input logic [8:0] c);
        @(negedge clk);
        hs = hv; vs = vv; {r, g, b} = c; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    // Drives one frame; badLine gets badLen samples; stops after maxSamples if >= 0.
    task automatic send_frame(input int nLines, input int badLine, input int badLen,
                              input int maxSamples);
        int n = 0;
        int len, ex, ey;
        logic [8:0] c;
        deCnt = 0; xyBad = 0; xMax = 0; yMax = 0; unlockPos = -1;
        for (int v = 0; v < nLines; v++) begin
            len = (v == badLine) ? badLen : HT;
            for (int h = 0; h < len; h++) begin
                if (maxSamples >= 0 && n >= maxSamples) return;
                ex = h - HO;
                ey = v - VO;
                c  = 9'h0;
                if (!zeroRgb && ex >= 0 && ex < HV) c = {3{ex[2:0]}};
                if (probeOn && ex == 2 && ey == 1) c = 9'h1A5;
                put_sample(h >= HS, v >= VS, c);
                n++;
                if (de) begin
                    deCnt++;
                    if (int'(x) > xMax) xMax = int'(x);
                    if (int'(y) > yMax) yMax = int'(y);
                    if (int'(x) != ex || int'(y) != ey || ex >= HV || ey >= VV || ey < 0)
                        xyBad++;
                end else if (x != 11'd0 || y != 11'd0) begin
                    xyBad++;
                end
                if (prevLocked && !locked && unlockPos < 0) unlockPos = v * 100 + h;
                prevLocked = locked;
            end
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    initial begin
        // 1: reset values, lock after second vs edge, visible window
        repeat (3) @(negedge clk);
        check("rst_locked", locked, 0);
        check("rst_de", de, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_line", err_line, 0);
        check("rst_err_frame", err_frame, 0);
        check("rst_probe_vld", probe_vld, 0);
        check("rst_probe_rgb", probe_rgb, 0);
        rst = 1'b1;
        send_frame(VT, -1, 0, -1);
        check("locked_after_vs1", locked, 0);
        send_frame(VT, -1, 0, -1);
        check("locked_after_vs2", locked, 1);
        check("de_per_frame", deCnt, HV * VV);
        check("xy_track", xyBad, 0);
        check("x_max", xMax, HV - 1);
        check("y_max", yMax, VV - 1);
        send_frame(VT, -1, 0, -1);
        check("frame_cnt_first", frame_cnt, 1);

        // 2: probe pixel capture and out-of-range probe
        probeOn = 1'b1; probe_x = 11'd2; probe_y = 11'd1; probeCnt = 0;
        send_frame(VT, -1, 0, -1);
        check("probe_vld_once", probeCnt, 1);
        check("probe_rgb", probe_rgb, 9'h1A5);
        probe_x = 11'd700; probeCnt = 0;
        send_frame(VT, -1, 0, -1);
        check("probe_out_of_range", probeCnt, 0);
        check("probe_rgb_hold", probe_rgb, 9'h1A5);

        // 3: short line while locked
        send_frame(VT, 2, HT - 1, -1);
        check("err_line_set", err_line, 1);
        check("unlock_on_line", locked, 0);
        check("unlock_at_sample", unlockPos, 300);
        pulse_clr();
        check("err_line_clr", err_line, 0);
        send_frame(VT, -1, 0, -1);
        check("relock_vs1", locked, 0);
        send_frame(VT, -1, 0, -1);
        check("relock_vs2", locked, 1);
        check("frame_cnt_after_line_err", frame_cnt, 4);

        // 4: short frame while locked
        send_frame(VT, -1, 0, -1);
        check("frame_cnt_d", frame_cnt, 5);
        send_frame(VT - 1, -1, 0, -1);
        check("frame_cnt_e", frame_cnt, 6);
        send_frame(VT, -1, 0, -1);
        check("err_frame_set", err_frame, 1);
        check("unlock_on_frame", locked, 0);
        check("unlock_frame_at", unlockPos, 0);
        check("frame_cnt_hold", frame_cnt, 6);
        check("err_line_quiet", err_line, 0);
        pulse_clr();
        check("err_frame_clr", err_frame, 0);

        // 5: relock, frame counter wrap, async reset mid-line
        send_frame(VT, -1, 0, -1);
        send_frame(VT, -1, 0, -1);
        check("relock_again", locked, 1);
        for (int i = 0; i < 249; i++) send_frame(VT, -1, 0, -1);
        check("frame_cnt_255", frame_cnt, 255);
        send_frame(VT, -1, 0, -1);
        check("frame_cnt_wrap", frame_cnt, 0);

`ifdef VGA_MON_CRC_EN
        // 6: CRC over an all-zero frame
        zeroRgb = 1'b1;
        send_frame(VT, -1, 0, -1);
        crcCnt = 0;
        send_frame(VT, -1, 0, -1);
        check("crc_vld_once", crcCnt, 1);
        check("frame_crc", frame_crc, crc_model(HV * VV));
        zeroRgb = 1'b0;
`endif

        send_frame(VT, -1, 0, 2 * HT + 5);
        check("pre_reset_de", de, 1);
        #2 rst = 1'b0;
        #1;
        check("areset_locked", locked, 0);
        check("areset_de", de, 0);
        check("areset_x", x, 0);
        check("areset_y", y, 0);
        check("areset_frame_cnt", frame_cnt, 0);
        check("areset_probe_rgb", probe_rgb, 0);
        repeat (2) @(negedge clk);
        hs = 1'b1; vs = 1'b1; rst = 1'b1; prevLocked = 1'b0;
        send_frame(VT, -1, 0, -1);
        check("post_reset_vs1", locked, 0);
        send_frame(VT, -1, 0, -1);
        check("post_reset_vs2", locked, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
